fetch_unit: RTL

//  Instruction fetch stage ahead of the decode/control unit. Holds the PC, issues
//  in-order requests to instruction memory, buffers returned words in a small

---
 rtl/mips_pkg.sv | 18 +
 rtl/fetch_queue.sv | 101 ++++++++++
 rtl/fetch_unit.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: opcodes, fetch defaults and the fetch FSM state type.
package mips_pkg;

    localparam int unsigned INSTR_W      = 32;
    localparam int unsigned PC_W_DEF     = 32;
    localparam int unsigned FQ_DEPTH_DEF = 4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    localparam logic [5:0]  OP_J   = 6'h02;
    localparam logic [5:0]  OP_HLT = 6'h3f;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_WAIT_KILL = 2'd1,
        ST_HALTED    = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode: DEPTH-entry FIFO of {instr, pc4}
// with registered head outputs, flush, and simultaneous push/pop even when full.
module fetch_queue
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PC_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [INSTR_W-1:0]       i_instr,
    input  logic [PC_W-1:0]          i_pc4,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_valid,
    output logic [INSTR_W-1:0]       o_instr,
    output logic [PC_W-1:0]          o_pc4
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [INSTR_W-1:0] r_instr [DEPTH];
    logic [PC_W-1:0]    r_pc4   [DEPTH];
    logic [AW-1:0]      r_rd;
    logic [AW-1:0]      r_wr;
    logic [CW-1:0]      r_count;
    logic               r_valid;
    logic [INSTR_W-1:0] r_head_instr;
    logic [PC_W-1:0]    r_head_pc4;

    logic               w_do_pop;
    logic               w_do_push;
    logic [CW-1:0]      w_left;
    logic [CW-1:0]      w_count_n;
    logic [AW-1:0]      w_rd_n;
    logic [INSTR_W-1:0] w_head_instr_n;
    logic [PC_W-1:0]    w_head_pc4_n;

    // Next head: bypass the pushed word when the queue would otherwise be empty.
    always_comb begin
        w_do_pop       = i_pop && r_valid;
        w_do_push      = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);
        w_left         = r_count - CW'(w_do_pop);
        w_count_n      = w_left + CW'(w_do_push);
        w_rd_n         = r_rd + AW'(w_do_pop);
        w_head_instr_n = '0;
        w_head_pc4_n   = '0;
        if (w_left == '0) begin
            if (w_do_push) begin
                w_head_instr_n = i_instr;
                w_head_pc4_n   = i_pc4;
            end
        end else begin
            w_head_instr_n = r_instr[w_rd_n];
            w_head_pc4_n   = r_pc4[w_rd_n];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd         <= '0;
            r_wr         <= '0;
            r_count      <= '0;
            r_valid      <= 1'b0;
            r_head_instr <= '0;
            r_head_pc4   <= '0;
        end else if (i_flush) begin
            r_rd         <= '0;
            r_wr         <= '0;
            r_count      <= '0;
            r_valid      <= 1'b0;
            r_head_instr <= '0;
            r_head_pc4   <= '0;
        end else begin
            r_rd         <= w_rd_n;
            if (w_do_push) begin
                r_wr <= r_wr + AW'(1);
            end
            r_count      <= w_count_n;
            r_valid      <= (w_count_n != '0);
            r_head_instr <= w_head_instr_n;
            r_head_pc4   <= w_head_pc4_n;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_instr[r_wr] <= i_instr;
            r_pc4[r_wr]   <= i_pc4;
        end
    end

    assign o_count = r_count;
    assign o_valid = r_valid;
    assign o_instr = r_head_instr;
    assign o_pc4   = r_head_pc4;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem requests, redirect/halt handling.
// Define JUMP_PREDECODE_EN to let returned J words redirect fetch internally.
module fetch_unit
    import mips_pkg::*;
#(
    parameter int unsigned     PC_W     = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF),
    parameter int unsigned     FQ_DEPTH = FQ_DEPTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [PC_W-1:0]    if_pc4,
    input  logic               id_ready,
    input  logic               redir_valid,
    input  logic [PC_W-1:0]    redir_pc,
    input  logic               halt,
    output logic               halted
);

    localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;

    fetch_state_t    r_state;
    fetch_state_t    w_state_n;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_n;
    logic [PC_W-1:0] r_addr;
    logic            r_req;
    logic            r_out;
    logic            r_halted;

    logic            w_resp;
    logic            w_pop;
    logic            w_push;
    logic            w_flush;
    logic            w_issue;
    logic [PC_W-1:0] w_issue_addr;
    logic [PC_W-1:0] w_pc4;
    logic [PC_W-1:0] w_next_fetch;
    logic [PC_W-1:0] w_base;
    logic [CW-1:0]   w_count;
    logic [CW-1:0]   w_cnt_after;

    fetch_queue #(
        .DEPTH (FQ_DEPTH),
        .PC_W  (PC_W)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_instr (imem_rdata),
        .i_pc4   (w_pc4),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_count (w_count),
        .o_valid (if_valid),
        .o_instr (if_instr),
        .o_pc4   (if_pc4)
    );

    // A response belongs to the outstanding request only after its request cycle.
    assign w_resp      = imem_rvalid && r_out && !r_req;
    assign w_pop       = if_valid && id_ready;
    assign w_pc4       = r_addr + PC_W'(4);
    assign w_cnt_after = w_count + CW'(w_resp) - CW'(w_pop);
    assign w_base      = redir_valid ? redir_pc : r_pc;

`ifdef JUMP_PREDECODE_EN
    always_comb begin
        w_next_fetch = r_pc;
        if (w_resp && (imem_rdata[31:26] == OP_J)) begin
            w_next_fetch = {w_pc4[PC_W-1:28], imem_rdata[25:0], 2'b00};
        end
    end
`else
    always_comb begin
        w_next_fetch = r_pc;
    end
`endif

    // Next-state, issue and queue control.
    always_comb begin
        w_state_n    = r_state;
        w_pc_n       = r_pc;
        w_issue      = 1'b0;
        w_issue_addr = r_pc;
        w_push       = 1'b0;
        w_flush      = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (halt) begin
                    w_state_n = ST_HALTED;
                    w_flush   = 1'b1;
                end else if (redir_valid) begin
                    w_flush = 1'b1;
                    if (r_out && !w_resp) begin
                        w_state_n = ST_WAIT_KILL;
                        w_pc_n    = redir_pc;
                    end else begin
                        w_issue      = 1'b1;
                        w_issue_addr = redir_pc;
                        w_pc_n       = redir_pc + PC_W'(4);
                    end
                end else begin
                    w_push = w_resp;
                    w_pc_n = w_next_fetch;
                    if ((!r_out || w_resp) && (w_cnt_after < CW'(FQ_DEPTH))) begin
                        w_issue      = 1'b1;
                        w_issue_addr = w_next_fetch;
                        w_pc_n       = w_next_fetch + PC_W'(4);
                    end
                end
            end
            ST_WAIT_KILL: begin
                if (halt) begin
                    w_state_n = ST_HALTED;
                    w_flush   = 1'b1;
                end else begin
                    w_pc_n = w_base;
                    if (w_resp) begin
                        w_state_n    = ST_RUN;
                        w_issue      = 1'b1;
                        w_issue_addr = w_base;
                        w_pc_n       = w_base + PC_W'(4);
                    end
                end
            end
            ST_HALTED: begin
                w_state_n = ST_HALTED;
            end
            default: begin
                w_state_n = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_pc     <= RESET_PC;
            r_addr   <= RESET_PC;
            r_req    <= 1'b0;
            r_out    <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_pc     <= w_pc_n;
            r_req    <= w_issue;
            if (w_issue) begin
                r_addr <= w_issue_addr;
            end
            if (w_issue) begin
                r_out <= 1'b1;
            end else if (w_resp) begin
                r_out <= 1'b0;
            end
            r_halted <= r_halted || (w_state_n == ST_HALTED);
        end
    end

    assign imem_req  = r_req;
    assign imem_addr = r_addr;
    assign halted    = r_halted;

endmodule
